// File: rtl/debounce_pkg.sv
// Shared types and constants for the shared-timer debouncer family.
package debounce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Same default lockout as the existing single-channel debouncers.
    localparam int unsigned DEFAULT_TIMER = 2_000_000;

    function automatic int unsigned idWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_arbiter_if.sv
// Pin-side bundle of the debounce arbiter: raw inputs in, clean levels and edge pulses out.
interface debounce_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned ID_W = debounce_pkg::idWidth(N);

    logic [N-1:0]    noisy_in;
    logic [N-1:0]    debounced_out;
    logic [N-1:0]    rise_pulse;
    logic [N-1:0]    fall_pulse;
    logic            busy;
    logic [ID_W-1:0] grant_id;

    modport master (
        input  noisy_in,
        output debounced_out, rise_pulse, fall_pulse, busy, grant_id
    );

    modport slave (
        output noisy_in,
        input  debounced_out, rise_pulse, fall_pulse, busy, grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after lastGrant_i, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] lastGrant_i,
    output logic            anyReq_o,
    output logic [ID_W-1:0] pickId_o
);

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx      = '0;
        anyReq_o = 1'b0;
        pickId_o = '0;
        for (int k = int'(N); k >= 1; k--) begin
            idx = ID_W'((int'(lastGrant_i) + k) % int'(N));
            if (req_i[idx]) begin
                anyReq_o = 1'b1;
                pickId_o = idx;
            end
        end
    end

endmodule

// File: rtl/timer_parameterized.sv
// Clearable, enableable up-counter that flags when it sits on end_at_i.
module timer_parameterized #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] end_at_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == end_at_i);

endmodule

// File: rtl/debounce_arbiter.sv
// Early-response debouncer for N inputs sharing one lockout timer through a round-robin grant.
module debounce_arbiter
    import debounce_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned TIMER = DEFAULT_TIMER
) (
    input logic                 clk,
    input logic                 reset_n,
    debounce_arbiter_if.master  bus
);

    localparam int unsigned ID_W  = idWidth(N);
    localparam int unsigned CNT_W = (TIMER > 1) ? $clog2(TIMER) : 1;

    logic [N-1:0]    sync1_q, sync2_q;
    logic [N-1:0]    deb_q, deb_d;
    logic [N-1:0]    rise_q, rise_d;
    logic [N-1:0]    fall_q, fall_d;
    logic            busy_q, busy_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] lastGrant_q, lastGrant_d;
    state_e          state_q, state_d;

    logic [N-1:0]    req;
    logic            anyReq;
    logic [ID_W-1:0] pickId;
    logic            timerDone;

    // The owner of the timer must not re-request while its lockout runs.
    always_comb begin
        req = sync2_q ^ deb_q;
        if (busy_q) begin
            req[grant_q] = 1'b0;
        end
    end

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req_i       (req),
        .lastGrant_i (lastGrant_q),
        .anyReq_o    (anyReq),
        .pickId_o    (pickId)
    );

    timer_parameterized #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (state_q == IDLE),
        .enable_i (state_q == LOCK),
        .end_at_i (CNT_W'(TIMER - 1)),
        .done_o   (timerDone)
    );

    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        rise_d      = '0;
        fall_d      = '0;
        busy_d      = busy_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    deb_d[pickId]  = sync2_q[pickId];
                    rise_d[pickId] = sync2_q[pickId];
                    fall_d[pickId] = ~sync2_q[pickId];
                    grant_d        = pickId;
                    busy_d         = 1'b1;
                    state_d        = LOCK;
                end
            end
            LOCK: begin
                if (timerDone) begin
                    busy_d      = 1'b0;
                    lastGrant_d = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // lastGrant resets to N-1 so channel 0 gets first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            lastGrant_q <= ID_W'(N - 1);
            state_q     <= IDLE;
        end else begin
            sync1_q     <= bus.noisy_in;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            state_q     <= state_d;
        end
    end

    assign bus.debounced_out = deb_q;
    assign bus.rise_pulse    = rise_q;
    assign bus.fall_pulse    = fall_q;
    assign bus.busy          = busy_q;
    assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter with N=4, TIMER=8; expected values are hand-derived.
module tb_debounce_arbiter;

    localparam int N     = 4;
    localparam int TIMER = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    int compareCount = 0;
    int failCount    = 0;

    int   busyCnt;
    int   riseCnt;
    int   fallCnt;
    int   seqIdx;
    int   firstRise [N];
    int   grantSeq  [4];
    logic overlap;

    debounce_arbiter_if #(.N(N)) bus ();

    debounce_arbiter #(
        .N     (N),
        .TIMER (TIMER)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Every sample and every input change happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] v);
        bus.noisy_in = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus('0);
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.noisy_in = '0;

        // Async reset: outputs must clear before any clock edge arrives.
        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset_deb",   32'(bus.debounced_out), 0);
        checkOutput("reset_rise",  32'(bus.rise_pulse),    0);
        checkOutput("reset_fall",  32'(bus.fall_pulse),    0);
        checkOutput("reset_busy",  32'(bus.busy),          0);
        checkOutput("reset_grant", 32'(bus.grant_id),      0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Single press on ch1: grant three edges later, busy for TIMER cycles.
        applyStimulus(4'b0010);
        busyCnt = 0;
        riseCnt = 0;
        fallCnt = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (bus.busy) busyCnt++;
            if (bus.rise_pulse[1]) riseCnt++;
            if (bus.fall_pulse != '0) fallCnt++;
            if (i == 2) checkOutput("press_deb_early", 32'(bus.debounced_out), 0);
            if (i == 3) begin
                checkOutput("press_deb",   32'(bus.debounced_out), 32'h2);
                checkOutput("press_rise",  32'(bus.rise_pulse),    32'h2);
                checkOutput("press_grant", 32'(bus.grant_id),      1);
                checkOutput("press_busy",  32'(bus.busy),          1);
            end
            if (i == 10) checkOutput("press_busy_last", 32'(bus.busy), 1);
            if (i == 11) checkOutput("press_busy_end",  32'(bus.busy), 0);
        end
        checkOutput("press_busy_cycles", 32'(busyCnt), 8);
        checkOutput("press_rise_count",  32'(riseCnt), 1);
        checkOutput("press_fall_count",  32'(fallCnt), 0);

        // Bounce on ch2: rises, toggles six times, ends high.
        applyStimulus(4'b0110);
        riseCnt = 0;
        fallCnt = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.rise_pulse[2]) riseCnt++;
            if (bus.fall_pulse[2]) fallCnt++;
            if (i == 3) checkOutput("bounce_grant", 32'(bus.grant_id), 2);
            if (i <= 6) applyStimulus((i % 2 == 0) ? 4'b0110 : 4'b0010);
        end
        checkOutput("bounce_rise_count", 32'(riseCnt), 1);
        checkOutput("bounce_fall_count", 32'(fallCnt), 0);
        checkOutput("bounce_deb",        32'(bus.debounced_out), 32'h6);
        checkOutput("bounce_busy",       32'(bus.busy), 0);

        // Ch3 glitches high for one cycle: level corrected one cycle after lockout.
        applyStimulus(4'b1110);
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) applyStimulus(4'b0110);
            if (i == 3) checkOutput("late_rise", 32'(bus.rise_pulse), 32'h8);
            if (i == 11) begin
                checkOutput("late_deb_held", 32'(bus.debounced_out), 32'he);
                checkOutput("late_no_fall",  32'(bus.fall_pulse),    0);
            end
            if (i == 12) begin
                checkOutput("late_deb",   32'(bus.debounced_out), 32'h6);
                checkOutput("late_fall",  32'(bus.fall_pulse),    32'h8);
                checkOutput("late_grant", 32'(bus.grant_id),      3);
            end
        end

        // Contention from reset: all rise together, served 0,1,2,3 nine cycles apart.
        doReset();
        applyStimulus(4'b1111);
        overlap = 1'b0;
        for (int c = 0; c < N; c++) firstRise[c] = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.rise_pulse != '0) begin
                if (!$onehot(bus.rise_pulse)) overlap = 1'b1;
                for (int c = 0; c < N; c++) begin
                    if (bus.rise_pulse[c] && firstRise[c] < 0) firstRise[c] = i;
                end
            end
        end
        checkOutput("contend_overlap", 32'(overlap), 0);
        checkOutput("contend_ch0", 32'(firstRise[0]), 3);
        checkOutput("contend_ch1", 32'(firstRise[1]), 12);
        checkOutput("contend_ch2", 32'(firstRise[2]), 21);
        checkOutput("contend_ch3", 32'(firstRise[3]), 30);
        checkOutput("contend_deb", 32'(bus.debounced_out), 32'hf);

        // Fairness: ch0 is granted first, then ch0 and ch3 request continuously.
        applyStimulus(4'b1110);
        repeat (3) tick();
        checkOutput("fair_first_fall",  32'(bus.fall_pulse), 32'h1);
        checkOutput("fair_first_grant", 32'(bus.grant_id),   0);
        seqIdx = 0;
        for (int g = 0; g < 4; g++) grantSeq[g] = -1;
        for (int i = 4; i <= 39; i++) begin
            applyStimulus({~bus.debounced_out[3], 2'b11, ~bus.debounced_out[0]});
            tick();
            if ((bus.rise_pulse | bus.fall_pulse) != '0 && seqIdx < 4) begin
                grantSeq[seqIdx] = int'(bus.grant_id);
                seqIdx++;
            end
        end
        checkOutput("fair_count",  32'(seqIdx), 4);
        checkOutput("fair_grant0", 32'(grantSeq[0]), 3);
        checkOutput("fair_grant1", 32'(grantSeq[1]), 0);
        checkOutput("fair_grant2", 32'(grantSeq[2]), 3);
        checkOutput("fair_grant3", 32'(grantSeq[3]), 0);

        // Dropped glitch: ch1 high for 4 cycles while ch0 owns the timer.
        doReset();
        applyStimulus(4'b0001);
        riseCnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.rise_pulse[1]) riseCnt++;
            if (i == 3) checkOutput("glitch_owner", 32'(bus.grant_id), 0);
            if (i == 4) applyStimulus(4'b0011);
            if (i == 8) applyStimulus(4'b0001);
        end
        checkOutput("glitch_rise1", 32'(riseCnt), 0);
        checkOutput("glitch_deb",   32'(bus.debounced_out), 32'h1);

        // Reset while LOCK counter is 4, then lowest requester wins after release.
        applyStimulus(4'b0101);
        repeat (3) tick();
        checkOutput("midlock_grant", 32'(bus.grant_id),   2);
        checkOutput("midlock_rise",  32'(bus.rise_pulse), 32'h4);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("midlock_rst_deb",   32'(bus.debounced_out), 0);
        checkOutput("midlock_rst_busy",  32'(bus.busy),          0);
        checkOutput("midlock_rst_grant", 32'(bus.grant_id),      0);
        checkOutput("midlock_rst_rise",  32'(bus.rise_pulse),    0);
        applyStimulus(4'b1110);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i < 3) checkOutput("release_no_pulse", 32'(bus.rise_pulse | bus.fall_pulse), 0);
        end
        checkOutput("release_rise",  32'(bus.rise_pulse),    32'h2);
        checkOutput("release_grant", 32'(bus.grant_id),      1);
        checkOutput("release_deb",   32'(bus.debounced_out), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
